sdram_ctrl: RTL and testbench
=============================

SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50: core clock frequency, for documentation and timing derivation.
REQ-002 SHALL have parameter INIT_CYCLES, default 10000: power-up wait of 200 us at 50 MHz; set to 20 in simulation.
REQ-003 SHALL have parameter REF_CYCLES, default 390: interval between refreshes (7.8 us at 50 MHz).
REQ-004 SHALL have parameters T_RP=2, T_RCD=2, T_RFC=7, T_WRAP=4, CAS=2, all in clock cycles.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port req, input, 1 bit: host access request.
REQ-008 SHALL have port we, input, 1 bit: 1 = write, 0 = read; valid with req.
REQ-009 SHALL have port addr, input, 24 bits: bank = [23:22], row = [21:9], col = [8:0].
REQ-010 SHALL have port wdata, input, 16 bits: write data; valid with req.
REQ-011 SHALL have port ready, output, 1 bit: request accepted on a cycle with req && ready.
REQ-012 SHALL have port rdata, output, 16 bits: read data.
REQ-013 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse qualifying rdata.
REQ-014 SHALL have port init_done, output, 1 bit: high once the initialization sequence is complete.
REQ-015 SHALL have outputs sdram_core_cke (1), sdram_core_cs (1, active-low), sdram_core_cmd (3, {ras_n,cas_n,we_n}), sdram_core_dqm (2), sdram_core_addr (13), sdram_core_ba (2), sdram_core_data_output (16) and sdram_core_data_out_en (1), all registered.
REQ-016 SHALL have input sdram_core_data_input, 16 bits: DQ pins returned from the pad block.

Function
REQ-017 SHALL use command encodings NOP=111, ACTIVE=011, READ=101, WRITE=100, PRECHARGE=010, REFRESH=001, LMR=000; every non-command cycle drives NOP with cs=0.
REQ-018 SHALL implement the FSM states INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR, IDLE, ACT, RW, RD_WAIT, WR_WAIT and REFRESH, with one shared down-counter for all waits.
REQ-019 INIT_WAIT: cke=1 and NOP for INIT_CYCLES; then PRECHARGE with addr[10]=1 (all banks) and wait T_RP.
REQ-020 INIT sequence: REFRESH in INIT_REF1 and wait T_RFC; REFRESH again in INIT_REF2 and wait T_RFC.
REQ-021 INIT_LMR: LMR with ba=0 and addr=13'h020 (BL1, sequential, CAS2), wait 2 cycles, then enter IDLE.
REQ-022 On entering IDLE: init_done=1 and dqm=00; init_done stays 1 until reset.
REQ-023 Refresh timer SHALL start counting at init_done; on reaching REF_CYCLES it sets ref_pending and restarts.
REQ-024 ref_pending SHALL be cleared in the cycle REFRESH is issued; a second expiry while pending is lost, not queued.
REQ-025 ready SHALL be 1 only in IDLE with ref_pending=0.
REQ-026 When IDLE with ref_pending=1, the FSM SHALL enter REFRESH and issue REFRESH, then wait T_RFC; refresh has priority over req.
REQ-027 On accept in cycle N, addr, we and wdata SHALL be latched; ACTIVE (ba=bank, addr=row) appears on outputs at edge N+1.
REQ-028 The READ/WRITE command SHALL appear T_RCD cycles after ACTIVE, with addr={3'b001,1'b0,col} giving A10=1 (auto-precharge).
REQ-029 Write: data_output=wdata and data_out_en=1 only in the WRITE cycle; then WR_WAIT for T_WRAP cycles, then IDLE.
REQ-030 Read: sdram_core_data_input SHALL be sampled CAS+1 cycles after the READ cycle, into rdata, with rdata_valid=1 for exactly that cycle.
REQ-031 Read completion: after the read sample, wait T_RP cycles, then IDLE.
REQ-032 req is ignored while ready=0; the host holds req until accepted; there is no back-to-back acceptance within one access.
REQ-033 data_out_en SHALL never be 1 in the same cycle as or within CAS+1 cycles after a READ command.

Reset
REQ-034 While rst=0 at a clock edge: state=INIT_WAIT, cke=0, cs=1, cmd=111, dqm=11, addr=0, ba=0, data_output=0, data_out_en=0.
REQ-035 Also while rst=0: ready=0, rdata=0, rdata_valid=0, init_done=0, ref_pending=0, and all counters cleared.
REQ-036 Reset asserted mid-access SHALL abort it with no rdata_valid pulse, and SHALL restart the full init sequence.

Verification
REQ-037 Init (INIT_CYCLES=20): release rst -> 20 NOPs with cke=1, then PRE(A10=1), then REF, then REF, then LMR with addr=0x020; init_done rises; exact spacing is T_RP, T_RFC, T_RFC, 2.
REQ-038 Write: req, we=1, addr=0x123456, wdata=0xBEEF -> ACTIVE with ba=0 and addr=0x91A; 2 cycles later WRITE with addr=0x456, dq=0xBEEF and data_out_en=1 for 1 cycle.
REQ-039 Read: same address with we=0, and the SDRAM model returns 0xBEEF -> READ with addr=0x456; rdata=0xBEEF with rdata_valid high 3 cycles after READ, for 1 cycle.
REQ-040 Collision: req asserted in the same cycle ref_pending sets -> ready=0; REFRESH is issued first; the request is accepted after T_RFC.
REQ-041 Refresh cadence: idle for 2000 cycles after init -> a REFRESH every 390 cycles (5 total), with no other commands.
REQ-042 Abort: rst=0 for 1 cycle between READ and data return -> no rdata_valid; outputs match reset values; init replays.

Source files
------------

// File: rtl/sdram_ctrl.sv
// Single-port SDRAM controller: power-up init, periodic auto-refresh and
// single-word (BL1) auto-precharge read/write accesses for a 16-bit device.
module sdram_ctrl #(
    parameter int CLK_MHZ     = 50,
    parameter int INIT_CYCLES = 10000,
    parameter int REF_CYCLES  = 390,
    parameter int T_RP        = 2,
    parameter int T_RCD       = 2,
    parameter int T_RFC       = 7,
    parameter int T_WRAP      = 4,
    parameter int CAS         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        init_done,
    output logic        sdram_core_cke,
    output logic        sdram_core_cs,
    output logic [2:0]  sdram_core_cmd,
    output logic [1:0]  sdram_core_dqm,
    output logic [12:0] sdram_core_addr,
    output logic [1:0]  sdram_core_ba,
    output logic [15:0] sdram_core_data_output,
    output logic        sdram_core_data_out_en,
    input  logic [15:0] sdram_core_data_input
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The shared wait counter never narrows below one microsecond of clocks.
    localparam int WAIT_MAX = max2(max2(CAS + T_RP, T_RFC), max2(T_WRAP, T_RCD));
    localparam int CNT_MAX  = max2(max2(INIT_CYCLES, CLK_MHZ), WAIT_MAX);
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int REF_W    = $clog2(REF_CYCLES + 1);

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PRE  = 4'd1;
    localparam logic [3:0] S_INIT_REF1 = 4'd2;
    localparam logic [3:0] S_INIT_REF2 = 4'd3;
    localparam logic [3:0] S_INIT_LMR  = 4'd4;
    localparam logic [3:0] S_IDLE      = 4'd5;
    localparam logic [3:0] S_ACT       = 4'd6;
    localparam logic [3:0] S_RW        = 4'd7;
    localparam logic [3:0] S_RD_WAIT   = 4'd8;
    localparam logic [3:0] S_WR_WAIT   = 4'd9;
    localparam logic [3:0] S_REFRESH   = 4'd10;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_pending_q, ref_pending_d;
    logic             init_done_q, init_done_d;
    logic             cke_q, cke_d;
    logic             cs_q, cs_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [1:0]       dqm_q, dqm_d;
    logic [12:0]      a_q, a_d;
    logic [1:0]       ba_q, ba_d;
    logic [15:0]      dout_q, dout_d;
    logic             dout_en_q, dout_en_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;

    logic             acc_we_q;
    logic [8:0]       acc_col_q;
    logic [15:0]      acc_wdata_q;
    logic             accept;

    assign ready  = (state_q == S_IDLE) && !ref_pending_q;
    assign accept = ready && req;

    always_ff @(posedge clk) begin
        if (accept) begin
            acc_we_q    <= we;
            acc_col_q   <= addr[8:0];
            acc_wdata_q <= wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        ref_cnt_d     = ref_cnt_q;
        ref_pending_d = ref_pending_q;
        init_done_d   = init_done_q;
        cke_d         = cke_q;
        cs_d          = 1'b0;
        cmd_d         = CMD_NOP;
        dqm_d         = dqm_q;
        a_d           = a_q;
        ba_d          = ba_q;
        dout_d        = '0;
        dout_en_d     = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                if (!cke_q) begin
                    cke_d = 1'b1;
                    cnt_d = CNT_W'(INIT_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    cmd_d   = CMD_PRE;
                    a_d     = 13'h0400;
                    state_d = S_INIT_PRE;
                    cnt_d   = CNT_W'(T_RP - 1);
                end
            end
            S_INIT_PRE: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    state_d = S_INIT_REF1;
                    cnt_d   = CNT_W'(T_RFC - 1);
                end
            end
            S_INIT_REF1: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    state_d = S_INIT_REF2;
                    cnt_d   = CNT_W'(T_RFC - 1);
                end
            end
            S_INIT_REF2: begin
                if (cnt_q == '0) begin
                    // Mode register: burst length 1, sequential, CAS latency 2.
                    cmd_d   = CMD_LMR;
                    ba_d    = 2'b00;
                    a_d     = 13'h0020;
                    state_d = S_INIT_LMR;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_INIT_LMR: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    dqm_d       = 2'b00;
                end
            end
            S_IDLE: begin
                if (ref_pending_q) begin
                    cmd_d         = CMD_REF;
                    ref_pending_d = 1'b0;
                    state_d       = S_REFRESH;
                    cnt_d         = CNT_W'(T_RFC - 1);
                end else if (req) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = addr[23:22];
                    a_d     = addr[21:9];
                    state_d = S_ACT;
                    cnt_d   = CNT_W'(T_RCD - 1);
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    a_d     = {3'b001, 1'b0, acc_col_q};
                    state_d = S_RW;
                    if (acc_we_q) begin
                        cmd_d     = CMD_WR;
                        dout_d    = acc_wdata_q;
                        dout_en_d = 1'b1;
                    end else begin
                        cmd_d = CMD_RD;
                    end
                end
            end
            S_RW: begin
                if (acc_we_q) begin
                    state_d = S_WR_WAIT;
                    cnt_d   = CNT_W'(T_WRAP - 1);
                end else begin
                    // One countdown covers the CAS delay and the trailing precharge.
                    state_d = S_RD_WAIT;
                    cnt_d   = CNT_W'(CAS + T_RP - 1);
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == CNT_W'(T_RP)) begin
                    rdata_d       = sdram_core_data_input;
                    rdata_valid_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_WR_WAIT, S_REFRESH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
            end
        endcase

        // An expiry wins over a same-cycle clear; one arriving while pending is dropped.
        if (init_done_q) begin
            if (ref_cnt_q == REF_W'(REF_CYCLES - 1)) begin
                ref_cnt_d     = '0;
                ref_pending_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_INIT_WAIT;
            cnt_q         <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            init_done_q   <= 1'b0;
            cke_q         <= 1'b0;
            cs_q          <= 1'b1;
            cmd_q         <= CMD_NOP;
            dqm_q         <= 2'b11;
            a_q           <= '0;
            ba_q          <= '0;
            dout_q        <= '0;
            dout_en_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            init_done_q   <= init_done_d;
            cke_q         <= cke_d;
            cs_q          <= cs_d;
            cmd_q         <= cmd_d;
            dqm_q         <= dqm_d;
            a_q           <= a_d;
            ba_q          <= ba_d;
            dout_q        <= dout_d;
            dout_en_q     <= dout_en_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign init_done              = init_done_q;
    assign rdata                  = rdata_q;
    assign rdata_valid            = rdata_valid_q;
    assign sdram_core_cke         = cke_q;
    assign sdram_core_cs          = cs_q;
    assign sdram_core_cmd         = cmd_q;
    assign sdram_core_dqm         = dqm_q;
    assign sdram_core_addr        = a_q;
    assign sdram_core_ba          = ba_q;
    assign sdram_core_data_output = dout_q;
    assign sdram_core_data_out_en = dout_en_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Scoreboard bench for sdram_ctrl: stimulus queues expected SDRAM commands and
// read returns with their edge numbers; a monitor pops and compares them.
module tb_sdram_ctrl;

    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
    localparam logic [2:0] PRE = 3'b010, REF = 3'b001, LMR = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        ready, rdata_valid, init_done;
    logic [15:0] rdata;
    logic        cke, cs, dout_en;
    logic [2:0]  cmd;
    logic [1:0]  dqm, ba;
    logic [12:0] a;
    logic [15:0] dout;
    logic [15:0] dq_in = '0;

    sdram_ctrl #(.INIT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid), .init_done(init_done),
        .sdram_core_cke(cke), .sdram_core_cs(cs), .sdram_core_cmd(cmd),
        .sdram_core_dqm(dqm), .sdram_core_addr(a), .sdram_core_ba(ba),
        .sdram_core_data_output(dout), .sdram_core_data_out_en(dout_en),
        .sdram_core_data_input(dq_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        bit          rdv;
        int          at;
        logic [12:0] a;
        logic [12:0] am;
        logic [1:0]  ba;
        bit          chk_ba;
        logic [15:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  vecs = 0;
    int  fails = 0;
    int  edge_n = -1;
    int  epoch = 1;
    int  ref_win = 0;
    int  rdv_total = 0;

    // Index of the last rising edge since reset release (-1 while in reset).
    always @(posedge clk) edge_n <= rst ? edge_n + 1 : -1;

    task automatic push(input logic [2:0] c, input bit r, input int at, input logic [12:0] ea,
                        input logic [12:0] am, input logic [1:0] eb, input bit cb, input logic [15:0] d);
        ev_t e;
        e.cmd = c; e.rdv = r; e.at = at; e.a = ea; e.am = am; e.ba = eb; e.chk_ba = cb; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(PRE, 0, 20, 13'h0400, 13'h0400, 2'd0, 0, 16'h0);
        push(REF, 0, 22, 13'h0, 13'h0, 2'd0, 0, 16'h0);
        push(REF, 0, 29, 13'h0, 13'h0, 2'd0, 0, 16'h0);
        push(LMR, 0, 36, 13'h0020, 13'h1FFF, 2'd0, 1, 16'h0);
    endtask

    task automatic score(input bit is_rdv);
        ev_t e;
        bit  ok;
        vecs++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected event at edge %0d: cmd=%b rdv=%0b, none required", edge_n, cmd, is_rdv);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.rdv == is_rdv) && (e.at == edge_n);
            if (!is_rdv)
                ok = ok && (cmd == e.cmd) && ((a & e.am) == (e.a & e.am)) && (!e.chk_ba || ba == e.ba)
                        && (cmd != WR || dout == e.d);
            else
                ok = ok && (rdata == e.d);
            if (!ok) begin
                fails++;
                $display("FAIL event: got edge=%0d cmd=%b rdv=%0b a=%h ba=%0d dq=%h rdata=%h; required edge=%0d cmd=%b rdv=%0b a=%h/%h ba=%0d data=%h",
                         edge_n, cmd, is_rdv, a, ba, dout, rdata, e.at, e.cmd, e.rdv, e.a, e.am, e.ba, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (edge_n >= 0) begin
            if (cs !== 1'b0 || dout_en !== (cmd == WR)) begin
                vecs++;
                fails++;
                $display("FAIL protocol at edge %0d: cs=%b dout_en=%b cmd=%b, required cs=0 and dout_en only with WRITE",
                         edge_n, cs, dout_en, cmd);
            end
            if (cmd != NOP) begin
                if (cmd == REF && epoch == 1 && edge_n > 38 && edge_n <= 2038) ref_win++;
                score(1'b0);
            end
            if (rdata_valid) begin
                rdv_total++;
                score(1'b1);
            end
        end
    end

    // SDRAM model: stores writes, returns read data only in the CAS-2 sample window.
    logic [15:0] mem [logic [23:0]];
    logic [12:0] open_row [4];
    int          rd_edge = -100;
    logic [15:0] rd_val = '0;
    always @(negedge clk) begin
        if (edge_n < 0) rd_edge = -100;
        else if (cmd == ACT) open_row[ba] = a;
        else if (cmd == WR) mem[{ba, open_row[ba], a[8:0]}] = dout;
        else if (cmd == RD) begin
            rd_edge = edge_n;
            rd_val  = mem.exists({ba, open_row[ba], a[8:0]}) ? mem[{ba, open_row[ba], a[8:0]}] : 16'h0000;
        end
        dq_in = (edge_n == rd_edge + 2) ? rd_val : 16'h0000;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic wait_edge(input int t);
        int n = 0;
        while (edge_n != t && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (edge_n != t) begin
            vecs++;
            fails++;
            $display("FAIL wait for edge %0d: timed out at edge %0d", t, edge_n);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, {cke, cs, cmd, dqm, a, ba, dout, dout_en, ready, rdata, rdata_valid, init_done},
                    {1'b0, 1'b1, 3'b111, 2'b11, 13'h0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0});
    endtask

    task automatic check_init(input string name);
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(cke == 1'b1 && cmd == NOP && cs == 1'b0)) bad++;
        end
        check({name, "_nop_cke"}, bad, 0);
        wait_edge(37);
        check({name, "_done_low"}, init_done, 1'b0);
        wait_edge(38);
        check({name, "_done_high"}, {init_done, ready, dqm}, {1'b1, 1'b1, 2'b00});
    endtask

    task automatic access(input bit w, input logic [23:0] ad, input logic [15:0] wd,
                          input logic [12:0] row_e, input logic [12:0] rw_a_e, input bit with_rdv,
                          input logic [15:0] rd_e, output int acc);
        int n = 0;
        acc = -1;
        req = 1'b1; we = w; addr = ad; wdata = wd;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            vecs++;
            fails++;
            $display("FAIL accept: ready never rose for addr %h", ad);
        end else begin
            acc = edge_n + 1;
            push(ACT, 0, acc, row_e, 13'h1FFF, 2'd0, 1, 16'h0);
            push(w ? WR : RD, 0, acc + 2, rw_a_e, 13'h1FFF, 2'd0, 1, wd);
            if (!w && with_rdv) push(NOP, 1, acc + 5, 13'h0, 13'h0, 2'd0, 0, rd_e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        check_reset("reset_values");
        push_init();
        for (int k = 0; k < 5; k++) push(REF, 0, 429 + 390 * k, 13'h0, 13'h0, 2'd0, 0, 16'h0);
        rst = 1'b1;
        check_init("init1");

        wait_edge(2038);
        check("refresh_cadence", ref_win, 5);

        access(1'b1, 24'h123456, 16'hBEEF, 13'h091A, 13'h0456, 1'b0, 16'h0, acc);
        access(1'b0, 24'h123456, 16'h0000, 13'h091A, 13'h0456, 1'b1, 16'hBEEF, acc);

        wait_edge(2378);
        check("collision_ready", ready, 1'b0);
        push(REF, 0, 2379, 13'h0, 13'h0, 2'd0, 0, 16'h0);
        access(1'b0, 24'h123456, 16'h0000, 13'h091A, 13'h0456, 1'b1, 16'hBEEF, acc);
        check("collision_accept_edge", acc, 2387);

        access(1'b0, 24'h123456, 16'h0000, 13'h091A, 13'h0456, 1'b0, 16'h0, acc);
        wait_edge(acc + 2);
        rst = 1'b0;
        @(negedge clk);
        check_reset("abort_reset_values");
        epoch = 2;
        push_init();
        rst = 1'b1;
        check_init("init2");

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("rdata_valid_pulses", rdv_total, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
